step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter STEPS, 8, number of pattern steps (power of two, 2..16).
REQ-002 Parameter NOTE_W, 7, note number width.
REQ-003 The block SHALL use one clock and synchronous active-high reset.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 tick_in  in  1  100 Hz square wave from the tempo comparator, synchronous to clk.
REQ-007 run  in  1  level; 1 = play, 0 = stop.
REQ-008 ticks_per_step  in  8  tempo ticks per step; 0 SHALL be treated as 1.
REQ-009 gate_len  in  8  ticks for which the gate stays high within a step.
REQ-010 wr_en  in  1  pattern write strobe.
REQ-011 wr_addr  in  log2(STEPS)  step to write.
REQ-012 wr_note  in  NOTE_W  note number to store.
REQ-013 wr_active  in  1  step enable bit to store.
REQ-014 note_out  out  NOTE_W  note of the current step, latched at step start.
REQ-015 gate_out  out  1  note gate.
REQ-016 step_idx  out  log2(STEPS)  current step index.
REQ-017 step_strobe  out  1  one-cycle pulse on each step start.

Function
REQ-018 A tick event SHALL occur in any cycle where sampled tick_in=1 and the previous sample was 0; the previous-sample register SHALL reset to 1 so that no spurious event follows reset.
REQ-019 States: IDLE, RUN; IDLE->RUN when run=1; RUN->IDLE when run=0; the transition takes effect on the same clk edge.
REQ-020 On IDLE->RUN: step_idx=0, tick_cnt=0, step 0 loaded, step_strobe=1 for that cycle; no tick is required.
REQ-021 In RUN, on each tick event: if tick_cnt == max(ticks_per_step,1)-1 then tick_cnt=0, step_idx advances, wrapping STEPS-1 -> 0, and step_strobe=1; otherwise tick_cnt increments.
REQ-022 Step load SHALL copy note[step] into note_out and active[step] into an internal step_active bit on the step_strobe edge.
REQ-023 gate_out SHALL be 1 while in RUN, step_active=1, and tick_cnt < gate_len; gate_len=0 keeps gate_out low; gate_len >= ticks_per_step keeps gate_out high across the step (legato).
REQ-024 Outputs SHALL be registered, with one clk latency from the sampled tick edge to step_idx, note_out, gate_out, and step_strobe.
REQ-025 In IDLE: gate_out=0, step_strobe=0, tick events ignored, step_idx and note_out hold.
REQ-026 Pattern writes SHALL be accepted in any state; a write to the currently playing step SHALL NOT change note_out until that step is next loaded.
REQ-027 A write and a step load of the same address in the same cycle SHALL load the old contents.
REQ-028 A ticks_per_step change mid-step SHALL apply from the next tick compare; if tick_cnt already >= the new limit, the next tick SHALL end the step.

Reset
REQ-029 Reset values: state IDLE, step_idx 0, tick_cnt 0, note_out 0, gate_out 0, step_strobe 0, step_active 0, and all pattern entries note 0 with active 0.
REQ-030 Reset SHALL override run and wr_en in the same cycle, and reset during RUN SHALL drop gate_out on the next edge.

Structure
REQ-031 A shared package SHALL hold the state encoding, STEPS, NOTE_W, and the pattern entry record (note plus active bit).
REQ-032 The pattern store SHALL be one sub-module, seq_pattern_ram: STEPS x (NOTE_W+1) registers, one write port, and one asynchronous read port.

Verification
REQ-033 Reset, then run=1, tpsp=4, gate_len=2, all steps active with note=10+i; strobe at cycle 1, then every 4 ticks; gate is high for 2 ticks per step; note_out sequence is 10..17, then wraps to 10.
REQ-034 Set ticks_per_step=0 and run; step_idx advances on every tick event.
REQ-035 Set step 3 to active=0; in step 3 gate_out stays 0 while step_strobe still pulses and note_out still updates.
REQ-036 Write step 2 with note=60 while step 2 is playing; note_out is unchanged until the next pass, then reads 60.
REQ-037 Drop run to 0 mid-step; gate_out goes to 0 next cycle and ticks are ignored; raise run again and step_idx restarts at 0 with a strobe.
REQ-038 Hold tick_in=1 through the rst release; no tick event is seen until tick_in goes 0 and then 1 again.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: sizing, FSM encoding and the
// pattern entry record stored per step.
package step_sequencer_pkg;

  localparam int STEPS  = 8;
  localparam int NOTE_W = 7;
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              active;
  } pat_entry_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern store: one register entry per step, single write port and an
// asynchronous read port, so a same-cycle write is seen only after the edge.
module seq_pattern_ram
  import step_sequencer_pkg::*;
#(
  parameter int DEPTH = STEPS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [$bits(pat_entry_t)-1:0] wr_data,
  input  logic [AW-1:0]                rd_addr,
  output logic [$bits(pat_entry_t)-1:0] rd_data
);

  pat_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= pat_entry_t'(wr_data);
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer: counts tick edges per step, plays the stored
// pattern and drives a registered note/gate/strobe interface.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | stopped; ticks ignored, gate low, step/note held
//   ST_RUN  | playing; ticks counted, steps advance and wrap
module step_sequencer #(
  parameter int STEPS  = step_sequencer_pkg::STEPS,
  parameter int NOTE_W = step_sequencer_pkg::NOTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_in,
  input  logic                     run,
  input  logic [7:0]               ticks_per_step,
  input  logic [7:0]               gate_len,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]        wr_note,
  input  logic                     wr_active,
  output logic [NOTE_W-1:0]        note_out,
  output logic                     gate_out,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_strobe
);
  import step_sequencer_pkg::*;

  localparam int SW = $clog2(STEPS);

  seq_state_t    state_q, state_d;
  logic          tick_prev_q;
  logic          tick_ev;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic [7:0]    tick_limit;
  logic          step_end;
  logic [SW-1:0] step_d;
  logic          load;
  logic          step_active_q;
  logic          active_d;
  logic          gate_d;
  pat_entry_t    wr_entry, rd_entry;

  assign tick_ev    = tick_in & ~tick_prev_q;
  assign tick_limit = (ticks_per_step == 8'd0) ? 8'd1 : ticks_per_step;
  // >= rather than == so a shortened step length ends the step on the next tick
  assign step_end   = (tick_cnt_q >= (tick_limit - 8'd1));

  always_comb begin
    state_d    = run ? ST_RUN : ST_IDLE;
    step_d     = step_idx;
    tick_cnt_d = tick_cnt_q;
    load       = 1'b0;
    if (state_q == ST_IDLE) begin
      if (run) begin
        step_d     = '0;
        tick_cnt_d = 8'd0;
        load       = 1'b1;
      end
    end else if (run && tick_ev) begin
      if (step_end) begin
        tick_cnt_d = 8'd0;
        step_d     = step_idx + 1'b1;
        load       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  assign wr_entry = '{note: wr_note, active: wr_active};
  assign active_d = load ? rd_entry.active : step_active_q;
  assign gate_d   = (state_d == ST_RUN) && active_d && (tick_cnt_d < gate_len);

  seq_pattern_ram #(
    .DEPTH (STEPS)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry),
    .rd_addr (step_d),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_prev_q   <= 1'b1;
      tick_cnt_q    <= 8'd0;
      step_idx      <= '0;
      note_out      <= '0;
      step_active_q <= 1'b0;
      gate_out      <= 1'b0;
      step_strobe   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_prev_q   <= tick_in;
      tick_cnt_q    <= tick_cnt_d;
      step_idx      <= step_d;
      step_active_q <= active_d;
      gate_out      <= gate_d;
      step_strobe   <= load;
      if (load) begin
        note_out <= rd_entry.note;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: tempo stepping, gating, pattern writes,
// run/stop, tempo changes and reset behaviour against hand-computed values.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       run;
  logic [7:0] tps;
  logic [7:0] gl;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_note;
  logic       wr_active;
  logic [6:0] note_out;
  logic       gate_out;
  logic [2:0] step_idx;
  logic       step_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ev_strobe;
  logic       ev_gate;
  logic [2:0] ev_step;
  logic [6:0] ev_note;

  logic [6:0] sh_note [8];
  logic       sh_act  [8];
  logic [6:0] cur_note;

  step_sequencer #(
    .STEPS  (8),
    .NOTE_W (7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick_in        (tick_in),
    .run            (run),
    .ticks_per_step (tps),
    .gate_len       (gl),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_note        (wr_note),
    .wr_active      (wr_active),
    .note_out       (note_out),
    .gate_out       (gate_out),
    .step_idx       (step_idx),
    .step_strobe    (step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    ev_strobe = step_strobe;
    ev_gate   = gate_out;
    ev_step   = step_idx;
    ev_note   = note_out;
  endtask

  // one tick event: outputs are captured right after the edge that sees it
  task automatic do_tick();
    tick_in = 1'b1;
    cyc();
    sample();
    tick_in = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] n, input logic act);
    wr_en     = 1'b1;
    wr_addr   = a;
    wr_note   = n;
    wr_active = act;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_in = 1'b0; run = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_note = '0; wr_active = 1'b0; tps = 8'd4; gl = 8'd2;
    cyc(); cyc();
    chk("rst_step",   step_idx,    0);
    chk("rst_note",   note_out,    0);
    chk("rst_gate",   gate_out,    0);
    chk("rst_strobe", step_strobe, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sh_note[i] = 7'(10 + i);
      sh_act[i]  = (i != 3);
      wr(3'(i), sh_note[i], sh_act[i]);
    end

    // two full passes plus wrap; step 2 rewritten while playing in pass one
    run = 1'b1;
    cyc();
    sample();
    for (int k = 0; k <= 16; k++) begin
      chk("step_strobe", ev_strobe, 1);
      chk("step_idx",    ev_step,   k % 8);
      chk("step_note",   ev_note,   sh_note[k % 8]);
      chk("step_gate0",  ev_gate,   sh_act[k % 8]);
      cur_note = sh_note[k % 8];
      for (int t = 1; t <= 3; t++) begin
        do_tick();
        chk("mid_strobe", ev_strobe, 0);
        chk("mid_gate",   ev_gate,   (sh_act[k % 8] && t < 2) ? 1 : 0);
        chk("mid_note",   ev_note,   cur_note);
        if (k == 2 && t == 1) begin
          sh_note[2] = 7'd60;
          wr(3'd2, 7'd60, 1'b1);
          chk("wr_hold_note", note_out, cur_note);
        end
      end
      if (k < 16) do_tick();
    end

    // stop mid-step, ticks ignored, restart at step 0
    do_tick();
    chk("pre_stop_step", ev_step, 1);
    chk("pre_stop_gate", ev_gate, 1);
    run = 1'b0;
    cyc();
    chk("stop_gate",   gate_out,    0);
    chk("stop_step",   step_idx,    1);
    do_tick();
    chk("idle_strobe", ev_strobe, 0);
    chk("idle_step",   ev_step,   1);
    chk("idle_gate",   ev_gate,   0);
    run = 1'b1;
    cyc();
    chk("restart_strobe", step_strobe, 1);
    chk("restart_step",   step_idx,    0);
    chk("restart_note",   note_out,    10);
    chk("restart_gate",   gate_out,    1);

    // ticks_per_step = 0 behaves as 1
    tps = 8'd0;
    for (int j = 1; j <= 3; j++) begin
      do_tick();
      chk("tps0_strobe", ev_strobe, 1);
      chk("tps0_step",   ev_step,   j);
    end

    // shorten the step after the count has passed the new limit
    tps = 8'd4;
    do_tick();
    chk("tpsch_strobe1", ev_strobe, 0);
    do_tick();
    chk("tpsch_strobe2", ev_strobe, 0);
    tps = 8'd2;
    do_tick();
    chk("tpsch_strobe3", ev_strobe, 1);
    chk("tpsch_step",    ev_step,   4);

    // legato gate, then reset while running with tick_in held high
    gl = 8'd255;
    chk("legato_gate0", gate_out, 1);
    do_tick();
    chk("legato_gate1", ev_gate, 1);
    rst = 1'b1; tick_in = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_note = 7'd99; wr_active = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("rstrun_gate",   gate_out,    0);
    chk("rstrun_step",   step_idx,    0);
    chk("rstrun_note",   note_out,    0);
    chk("rstrun_strobe", step_strobe, 0);
    cyc();
    rst = 1'b0; tps = 8'd0;
    cyc();
    chk("post_rst_strobe", step_strobe, 1);
    chk("post_rst_step",   step_idx,    0);
    chk("post_rst_note",   note_out,    0);
    chk("post_rst_gate",   gate_out,    0);
    cyc(); cyc();
    chk("held_tick_step",   step_idx,    0);
    chk("held_tick_strobe", step_strobe, 0);
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
    chk("new_edge_strobe", step_strobe, 1);
    chk("new_edge_step",   step_idx,    1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
